// File: rtl/dfd_apb2mmr_mc_pkg.sv
// Shared types and sizing helpers for the DFD APB-to-MMR multi-channel bridge.
package dfd_apb2mmr_mc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DELAY = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  // Bits needed to hold the value max_val (never less than one).
  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

  // Bits needed to index n entries (never less than one).
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dfd_apb_addr_decode.sv
// Combinational APB address decode: channel window select and slow-read address match.
module dfd_apb_addr_decode
  import dfd_apb2mmr_mc_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int APB_ADDR_WIDTH = 23,
  parameter int CH_WIN_BITS    = 12,
  parameter logic [NUM_CH*APB_ADDR_WIDTH-1:0] CH_BASE = {NUM_CH{{APB_ADDR_WIDTH{1'b0}}}},
  parameter int NUM_SLOW       = 2,
  parameter logic [NUM_SLOW*APB_ADDR_WIDTH-1:0] SLOW_ADDR = {NUM_SLOW{{APB_ADDR_WIDTH{1'b0}}}},
  localparam int IDX_W         = idx_width(NUM_CH)
) (
  input  logic [APB_ADDR_WIDTH-1:0] paddr,
  output logic [IDX_W-1:0]          ch_idx,
  output logic                      ch_hit,
  output logic                      slow_hit
);

  localparam int TAG_W = APB_ADDR_WIDTH - CH_WIN_BITS;

  // Window match walks from the top channel down so the lowest index wins on overlap.
  always_comb begin
    ch_idx   = {IDX_W{1'b0}};
    ch_hit   = 1'b0;
    slow_hit = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (paddr[APB_ADDR_WIDTH-1:CH_WIN_BITS] ==
          CH_BASE[i*APB_ADDR_WIDTH + CH_WIN_BITS +: TAG_W]) begin
        ch_idx = IDX_W'(i);
        ch_hit = 1'b1;
      end else begin
        ch_idx = ch_idx;
        ch_hit = ch_hit;
      end
    end
    for (int j = 0; j < NUM_SLOW; j++) begin
      slow_hit = slow_hit | (paddr == SLOW_ADDR[j*APB_ADDR_WIDTH +: APB_ADDR_WIDTH]);
    end
  end

endmodule

// File: rtl/dfd_apb2mmr_mc.sv
// APB completer bridged onto NUM_CH MMR target windows with per-channel ack,
// delayed issue for slow reads and an ack timeout.
module dfd_apb2mmr_mc
  import dfd_apb2mmr_mc_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int DATA_WIDTH     = 64,
  parameter int APB_ADDR_WIDTH = 23,
  parameter int MMR_ADDR_WIDTH = 23,
  parameter int CH_WIN_BITS    = 12,
  parameter logic [NUM_CH*APB_ADDR_WIDTH-1:0] CH_BASE = {NUM_CH{{APB_ADDR_WIDTH{1'b0}}}},
  parameter int NUM_SLOW       = 2,
  parameter logic [NUM_SLOW*APB_ADDR_WIDTH-1:0] SLOW_ADDR = {NUM_SLOW{{APB_ADDR_WIDTH{1'b0}}}},
  parameter int SLOW_RD_DELAY  = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [APB_ADDR_WIDTH-1:0]    paddr,
  input  logic                         psel,
  input  logic                         penable,
  input  logic                         pwrite,
  input  logic [DATA_WIDTH/8-1:0]      pstrb,
  input  logic [DATA_WIDTH-1:0]        pwdata,
  output logic                         pready,
  output logic [DATA_WIDTH-1:0]        prdata,
  output logic                         pslverr,
  output logic [NUM_CH-1:0]            CsrCs,
  output logic                         CsrWrEn,
  output logic [DATA_WIDTH/32-1:0]     CsrWrStrb,
  output logic [MMR_ADDR_WIDTH-1:0]    CsrAddr,
  output logic [DATA_WIDTH-1:0]        CsrWrData,
  input  logic [NUM_CH-1:0]            CsrAck,
  input  logic [NUM_CH-1:0]            CsrHit,
  input  logic [NUM_CH-1:0]            CsrError,
  input  logic [NUM_CH*DATA_WIDTH-1:0] CsrRdData,
  output logic                         err_miss,
  output logic                         err_timeout
);

  localparam int IDX_W = idx_width(NUM_CH);
  localparam int TO_W  = cnt_width(TIMEOUT_CYCLES);
  localparam int DLY_W = cnt_width(SLOW_RD_DELAY);
  localparam int LANES = DATA_WIDTH / 32;

  localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [DLY_W-1:0] DLY_ONE  = DLY_W'(1);
  localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(SLOW_RD_DELAY);

  state_e                  state_r, state_next_s;
  logic [IDX_W-1:0]        dec_idx_s, ch_sel_s;
  logic                    dec_hit_s, dec_slow_s;
  logic                    start_s, ack_s, miss_s, tmo_s;
  logic [LANES-1:0]        lane_strb_s;
  logic [DATA_WIDTH-1:0]   rd_slice_s;

  logic [MMR_ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0]     wdata_r;
  logic                      wr_r;
  logic [LANES-1:0]          strb_r;
  logic [IDX_W-1:0]          ch_r;
  logic [DLY_W-1:0]          dly_cnt_r;
  logic [TO_W-1:0]           to_cnt_r;
  logic [NUM_CH-1:0]         cs_r;
  logic                      pready_r, pslverr_r, err_miss_r, err_timeout_r;
  logic [DATA_WIDTH-1:0]     prdata_r;

  dfd_apb_addr_decode #(
    .NUM_CH         (NUM_CH),
    .APB_ADDR_WIDTH (APB_ADDR_WIDTH),
    .CH_WIN_BITS    (CH_WIN_BITS),
    .CH_BASE        (CH_BASE),
    .NUM_SLOW       (NUM_SLOW),
    .SLOW_ADDR      (SLOW_ADDR)
  ) u_decode (
    .paddr    (paddr),
    .ch_idx   (dec_idx_s),
    .ch_hit   (dec_hit_s),
    .slow_hit (dec_slow_s)
  );

  assign start_s    = psel & ~penable;
  assign ch_sel_s   = (state_r == ST_IDLE) ? dec_idx_s : ch_r;
  assign ack_s      = CsrAck[ch_r];
  assign rd_slice_s = CsrRdData[ch_r*DATA_WIDTH +: DATA_WIDTH];

  // A 32-bit lane is written only when all four of its byte strobes are set.
  always_comb begin
    lane_strb_s = {LANES{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      lane_strb_s[i] = &pstrb[4*i +: 4];
    end
  end

  // Next-state decode with the miss and timeout qualifiers for the response.
  always_comb begin
    state_next_s = state_r;
    miss_s       = 1'b0;
    tmo_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!start_s) begin
          state_next_s = ST_IDLE;
        end else if (!dec_hit_s) begin
          state_next_s = ST_RESP;
          miss_s       = 1'b1;
        end else if (dec_slow_s && !pwrite) begin
          state_next_s = ST_DELAY;
        end else begin
          state_next_s = ST_ISSUE;
        end
      end
      ST_DELAY: begin
        if (!psel)                        state_next_s = ST_IDLE;
        else if (dly_cnt_r == DLY_ONE)    state_next_s = ST_ISSUE;
        else                              state_next_s = ST_DELAY;
      end
      ST_ISSUE: begin
        if (!psel)       state_next_s = ST_IDLE;
        else if (ack_s)  state_next_s = ST_RESP;
        else             state_next_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (!psel) begin
          state_next_s = ST_IDLE;
        end else if (ack_s) begin
          state_next_s = ST_RESP;
        end else if (to_cnt_r == TO_LAST) begin
          state_next_s = ST_RESP;
          tmo_s        = 1'b1;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_RESP: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_next_s;
  end

  // Transfer capture: loaded at setup, cleared whenever the bridge returns to idle.
  always_ff @(posedge clk) begin
    if (reset || state_next_s == ST_IDLE) begin
      addr_r  <= {MMR_ADDR_WIDTH{1'b0}};
      wdata_r <= {DATA_WIDTH{1'b0}};
      wr_r    <= 1'b0;
      strb_r  <= {LANES{1'b0}};
      ch_r    <= {IDX_W{1'b0}};
    end else if (state_r == ST_IDLE) begin
      addr_r  <= paddr[MMR_ADDR_WIDTH-1:0];
      wdata_r <= pwdata;
      wr_r    <= pwrite;
      strb_r  <= lane_strb_s;
      ch_r    <= dec_idx_s;
    end
  end

  // Slow-read delay and ack-timeout counters; the issue cycle counts as the first wait cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      dly_cnt_r <= {DLY_W{1'b0}};
      to_cnt_r  <= {TO_W{1'b0}};
    end else begin
      if (state_r == ST_IDLE && state_next_s == ST_DELAY) dly_cnt_r <= DLY_LOAD;
      else if (state_next_s == ST_DELAY)                  dly_cnt_r <= dly_cnt_r - DLY_ONE;
      else                                                dly_cnt_r <= {DLY_W{1'b0}};
      if (state_next_s == ST_WAIT && state_r == ST_ISSUE) to_cnt_r <= TO_ONE;
      else if (state_next_s == ST_WAIT)                   to_cnt_r <= to_cnt_r + TO_ONE;
      else                                                to_cnt_r <= {TO_W{1'b0}};
    end
  end

  // Registered chip select and APB response, all set up on the edge entering their state.
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_r          <= {NUM_CH{1'b0}};
      pready_r      <= 1'b0;
      prdata_r      <= {DATA_WIDTH{1'b0}};
      pslverr_r     <= 1'b0;
      err_miss_r    <= 1'b0;
      err_timeout_r <= 1'b0;
    end else begin
      cs_r          <= (state_next_s == ST_ISSUE) ? (NUM_CH'(1'b1) << ch_sel_s) : {NUM_CH{1'b0}};
      pready_r      <= (state_next_s == ST_RESP);
      err_miss_r    <= miss_s;
      err_timeout_r <= tmo_s;
      if (state_next_s == ST_RESP) begin
        prdata_r  <= (miss_s || tmo_s) ? {DATA_WIDTH{1'b0}} : rd_slice_s;
        pslverr_r <= miss_s | tmo_s | ~CsrHit[ch_r] | CsrError[ch_r];
      end else begin
        prdata_r  <= {DATA_WIDTH{1'b0}};
        pslverr_r <= 1'b0;
      end
    end
  end

  assign pready      = pready_r;
  assign prdata      = prdata_r;
  assign pslverr     = pslverr_r;
  assign err_miss    = err_miss_r;
  assign err_timeout = err_timeout_r;
  assign CsrCs       = cs_r;
  assign CsrWrEn     = wr_r;
  assign CsrWrStrb   = strb_r;
  assign CsrAddr     = addr_r;
  assign CsrWrData   = wdata_r;

endmodule

// File: tb/tb_dfd_apb2mmr_mc.sv
// Directed bench for dfd_apb2mmr_mc: table of APB transfers with expected
// timing/response, plus hand sequences for late ack, abort and mid-transfer reset.
module tb_dfd_apb2mmr_mc;

  localparam int NO_ACK = -1;

  logic          clk = 1'b0;
  logic          reset;
  logic [22:0]   paddr;
  logic          psel, penable, pwrite;
  logic [7:0]    pstrb;
  logic [63:0]   pwdata;
  logic          pready;
  logic [63:0]   prdata;
  logic          pslverr;
  logic [3:0]    CsrCs;
  logic          CsrWrEn;
  logic [1:0]    CsrWrStrb;
  logic [22:0]   CsrAddr;
  logic [63:0]   CsrWrData;
  logic [3:0]    CsrAck, CsrHit, CsrError;
  logic [255:0]  CsrRdData;
  logic          err_miss, err_timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dfd_apb2mmr_mc #(
    .NUM_CH         (4),
    .DATA_WIDTH     (64),
    .APB_ADDR_WIDTH (23),
    .MMR_ADDR_WIDTH (23),
    .CH_WIN_BITS    (12),
    .CH_BASE        ({23'h013000, 23'h012000, 23'h011000, 23'h010000}),
    .NUM_SLOW       (2),
    .SLOW_ADDR      ({23'h012100, 23'h010040}),
    .SLOW_RD_DELAY  (2),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk(clk), .reset(reset), .paddr(paddr), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pstrb(pstrb), .pwdata(pwdata), .pready(pready),
    .prdata(prdata), .pslverr(pslverr), .CsrCs(CsrCs), .CsrWrEn(CsrWrEn),
    .CsrWrStrb(CsrWrStrb), .CsrAddr(CsrAddr), .CsrWrData(CsrWrData),
    .CsrAck(CsrAck), .CsrHit(CsrHit), .CsrError(CsrError), .CsrRdData(CsrRdData),
    .err_miss(err_miss), .err_timeout(err_timeout)
  );

  typedef struct {
    logic        wr;
    logic [22:0] addr;
    logic [7:0]  strb;
    logic [63:0] wdata;
    int          ch;
    int          ack_dly;
    logic        hit;
    logic        err;
    logic        decoy;
    logic [63:0] rdata;
    logic [3:0]  exp_cs;
    int          exp_cs_k;
    logic [1:0]  exp_strb;
    int          exp_rdy_k;
    logic [63:0] exp_prdata;
    logic        exp_slverr;
    logic        exp_miss;
    logic        exp_to;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One APB transfer, T0 = setup cycle; k counts clock edges after T0.
  task automatic do_xfer(input int idx, input vec_t v);
    int          cs_k, rdy_k, n_cs;
    logic [3:0]  cs_v;
    logic [1:0]  strb_v;
    logic        bus_ok, err_v, miss_v, to_v;
    logic [63:0] rd_v;
    cs_k = -1; rdy_k = -1; n_cs = 0;
    cs_v = 4'h0; strb_v = 2'b00; bus_ok = 1'b0;
    err_v = 1'b0; miss_v = 1'b0; to_v = 1'b0; rd_v = 64'h0;
    paddr = v.addr; pwrite = v.wr; pstrb = v.strb; pwdata = v.wdata;
    CsrRdData[v.ch*64 +: 64] = v.rdata;
    CsrHit[v.ch] = v.hit;
    CsrError[v.ch] = v.err;
    psel = 1'b1; penable = 1'b0;
    for (int k = 1; k <= 100 && rdy_k < 0; k++) begin
      @(posedge clk); #1;
      penable = 1'b1;
      CsrAck = 4'h0;
      if (CsrCs != 4'h0) begin
        n_cs++;
        if (cs_k < 0) begin
          cs_k = k; cs_v = CsrCs; strb_v = CsrWrStrb;
          bus_ok = (CsrAddr == v.addr) && (CsrWrData == v.wdata) && (CsrWrEn == v.wr);
        end
      end
      if (pready) begin
        rdy_k = k; rd_v = prdata; err_v = pslverr; miss_v = err_miss; to_v = err_timeout;
      end else if (cs_k >= 0 && v.ack_dly >= 0 && k == cs_k + v.ack_dly) begin
        CsrAck[v.ch] = 1'b1;
      end
      if (v.decoy && k == cs_k) begin
        CsrAck[(v.ch + 1) % 4] = 1'b1;
        CsrError[(v.ch + 1) % 4] = 1'b1;
      end
    end
    psel = 1'b0; penable = 1'b0;
    CsrAck = 4'h0; CsrHit = 4'h0; CsrError = 4'h0; CsrRdData = 256'h0;
    check($sformatf("v%0d_cs", idx), 64'(cs_v), 64'(v.exp_cs));
    check($sformatf("v%0d_cs_cycle", idx), 64'(cs_k), 64'(v.exp_cs_k));
    check($sformatf("v%0d_cs_pulses", idx), 64'(n_cs), (v.exp_cs != 4'h0) ? 64'd1 : 64'd0);
    check($sformatf("v%0d_pready_cycle", idx), 64'(rdy_k), 64'(v.exp_rdy_k));
    check($sformatf("v%0d_prdata", idx), rd_v, v.exp_prdata);
    check($sformatf("v%0d_pslverr", idx), 64'(err_v), 64'(v.exp_slverr));
    check($sformatf("v%0d_err_miss", idx), 64'(miss_v), 64'(v.exp_miss));
    check($sformatf("v%0d_err_timeout", idx), 64'(to_v), 64'(v.exp_to));
    if (cs_k >= 0) begin
      check($sformatf("v%0d_wrstrb", idx), 64'(strb_v), 64'(v.exp_strb));
      check($sformatf("v%0d_bus", idx), 64'(bus_ok), 64'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int seen;
    //          wr    addr         strb   wdata                  ch dly     hit   err   decoy rdata
    //          exp_cs k  strb   rdy exp_prdata             slv   miss  to
    tbl[0]  = '{1'b1, 23'h011008, 8'hF0, 64'hA5A5_0000_1234_5678, 1, 0,      1'b1, 1'b0, 1'b0, 64'h0,
                4'b0010, 1, 2'b10, 2,  64'h0,                 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 23'h012010, 8'h00, 64'h0,                  2, 3,      1'b1, 1'b0, 1'b0, 64'hDEAD_BEEF_0123_4567,
                4'b0100, 1, 2'b00, 5,  64'hDEAD_BEEF_0123_4567, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 23'h010040, 8'h00, 64'h0,                  0, 0,      1'b1, 1'b0, 1'b0, 64'h1111_2222_3333_4444,
                4'b0001, 3, 2'b00, 4,  64'h1111_2222_3333_4444, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 23'h010040, 8'hFF, 64'h0BAD_F00D_CAFE_0001, 0, 0,      1'b1, 1'b0, 1'b0, 64'h0,
                4'b0001, 1, 2'b11, 2,  64'h0,                 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 23'h020000, 8'h00, 64'h0,                  0, NO_ACK, 1'b1, 1'b0, 1'b0, 64'h7777_7777_7777_7777,
                4'b0000, -1, 2'b00, 1, 64'h0,                 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 23'h013000, 8'h00, 64'h0,                  3, 0,      1'b0, 1'b0, 1'b0, 64'h3333_0000_0000_3333,
                4'b1000, 1, 2'b00, 2,  64'h3333_0000_0000_3333, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 23'h010008, 8'h00, 64'h0,                  0, 1,      1'b1, 1'b1, 1'b0, 64'h0000_0000_FFFF_0000,
                4'b0001, 1, 2'b00, 3,  64'h0000_0000_FFFF_0000, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 23'h011000, 8'h00, 64'h0,                  1, NO_ACK, 1'b1, 1'b0, 1'b0, 64'h5555_AAAA_5555_AAAA,
                4'b0010, 1, 2'b00, 65, 64'h0,                 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 23'h011010, 8'h00, 64'h0,                  1, 0,      1'b1, 1'b0, 1'b0, 64'h0123_4567_89AB_CDEF,
                4'b0010, 1, 2'b00, 2,  64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 23'h012100, 8'h00, 64'h0,                  2, 2,      1'b1, 1'b0, 1'b0, 64'hFEED_FACE_0000_0042,
                4'b0100, 3, 2'b00, 6,  64'hFEED_FACE_0000_0042, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 23'h012008, 8'h0F, 64'h1122_3344_5566_7788, 2, 0,      1'b1, 1'b0, 1'b0, 64'h0,
                4'b0100, 1, 2'b01, 2,  64'h0,                 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 23'h011020, 8'h00, 64'h0,                  1, 2,      1'b1, 1'b0, 1'b1, 64'h00C0_FFEE_0000_0001,
                4'b0010, 1, 2'b00, 4,  64'h00C0_FFEE_0000_0001, 1'b0, 1'b0, 1'b0};

    reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 23'h0; pstrb = 8'h0; pwdata = 64'h0;
    CsrAck = 4'h0; CsrHit = 4'h0; CsrError = 4'h0; CsrRdData = 256'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          {58'h0, pready, pslverr, err_miss, err_timeout, CsrWrEn, |CsrCs},
          64'h0);
    check("reset_bus", 64'(CsrAddr) | CsrWrData | 64'(CsrWrStrb) | prdata, 64'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      do_xfer(i, tbl[i]);
      @(posedge clk); #1;
      if (tbl[i].exp_to) begin
        // Late ack on the timed-out channel must not produce a response.
        seen = 0;
        CsrAck = 4'b0010; CsrHit = 4'b1111;
        for (int c = 0; c < 3; c++) begin
          @(posedge clk); #1;
          CsrAck = 4'h0;
          if (pready || CsrCs != 4'h0) seen++;
        end
        CsrHit = 4'h0;
        check("late_ack_ignored", 64'(seen), 64'd0);
      end
    end

    // psel dropped during ISSUE: abort to idle, no pready.
    paddr = 23'h011000; pwrite = 1'b0; pstrb = 8'h0; pwdata = 64'h0;
    psel = 1'b1; penable = 1'b0;
    @(posedge clk); #1;
    check("abort_cs", 64'(CsrCs), 64'h2);
    psel = 1'b0; penable = 1'b0;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (pready || CsrCs != 4'h0) seen++;
    end
    check("abort_no_pready", 64'(seen), 64'd0);
    check("abort_bus_idle", 64'(CsrAddr), 64'h0);

    // Reset asserted while waiting for ack.
    paddr = 23'h012000; psel = 1'b1; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; psel = 1'b0; penable = 1'b0;
    check("midreset_outputs",
          {58'h0, pready, pslverr, err_miss, err_timeout, CsrWrEn, |CsrCs}, 64'h0);
    check("midreset_addr", 64'(CsrAddr), 64'h0);
    seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (pready || CsrCs != 4'h0) seen++;
    end
    check("midreset_quiet", 64'(seen), 64'd0);
    do_xfer(100, tbl[8]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dfd_apb2mmr_mc.md
Name: dfd_apb2mmr_mc

Overview:
- Multi-channel APB-to-MMR bridge for the DFD debug fabric.
- Decodes one APB completer port onto NUM_CH independent MMR target windows (trace, funnel, timestamp, …).
- Adds per-channel ack handshake, programmable extra read-setup delay for slow (SRAM-backed) registers, and a response timeout.
- Sits between the DFD APB interconnect and the per-block CSR decoders.

Parameters:
- NUM_CH, 4, number of MMR target channels (1..8).
- DATA_WIDTH, 64, APB/MMR data width; multiple of 32.
- APB_ADDR_WIDTH, 23, APB address width.
- MMR_ADDR_WIDTH, 23, MMR address width; ≤ APB_ADDR_WIDTH.
- CH_WIN_BITS, 12, log2 of each channel window size in bytes.
- CH_BASE, {NUM_CH{APB_ADDR_WIDTH'h0}}, packed channel window bases; each aligned to 2^CH_WIN_BITS.
- NUM_SLOW, 2, number of slow-read addresses (≥1).
- SLOW_ADDR, {NUM_SLOW{APB_ADDR_WIDTH'h0}}, packed full APB addresses needing delayed read issue.
- SLOW_RD_DELAY, 2, extra cycles before CsrCs for slow reads (1..15).
- TIMEOUT_CYCLES, 64, max cycles waiting for CsrAck (≥2).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- paddr  in  APB_ADDR_WIDTH  APB address
- psel  in  1  APB select
- penable  in  1  APB enable
- pwrite  in  1  APB write
- pstrb  in  DATA_WIDTH/8  APB byte strobes
- pwdata  in  DATA_WIDTH  APB write data
- pready  out  1  APB ready
- prdata  out  DATA_WIDTH  APB read data
- pslverr  out  1  APB error
- CsrCs  out  NUM_CH  one-hot per-channel chip select, 1-cycle pulse
- CsrWrEn  out  1  write transfer
- CsrWrStrb  out  DATA_WIDTH/32  32-bit lane strobes
- CsrAddr  out  MMR_ADDR_WIDTH  captured paddr[MMR_ADDR_WIDTH-1:0]
- CsrWrData  out  DATA_WIDTH  captured pwdata
- CsrAck  in  NUM_CH  per-channel completion pulse
- CsrHit  in  NUM_CH  address hit, valid with CsrAck
- CsrError  in  NUM_CH  access error, valid with CsrAck
- CsrRdData  in  NUM_CH*DATA_WIDTH  per-channel read data, valid with CsrAck
- err_miss  out  1  pulse: decode miss
- err_timeout  out  1  pulse: ack timeout

Behaviour:
- Reset: state IDLE; all outputs 0; capture registers and counters 0.
- IDLE, on psel & ~penable (T0), capture:
  - paddr, pwrite, pwdata;
  - lane strobes, lane i = &pstrb[4i+:4];
  - channel index and hit: paddr within [CH_BASE[i], CH_BASE[i] + 2^CH_WIN_BITS); lowest i wins on overlap;
  - slow flag: ~pwrite & paddr matches any SLOW_ADDR.
- IDLE next state: no channel hit → RESP with miss=1 (no CsrCs); slow → DELAY (counter = SLOW_RD_DELAY); else → ISSUE.
- DELAY: counter decrements each cycle; at 1 → ISSUE.
- ISSUE: CsrCs[ch] = 1 for exactly one cycle; timeout counter cleared; CsrAck[ch] sampled this cycle.
  - Ack → RESP.
  - No ack → WAIT.
- WAIT: CsrAck[ch] sampled each cycle. Ack → RESP. Counter reaches TIMEOUT_CYCLES → RESP with to=1.
- RESP: pready = 1 for one cycle; then IDLE.
  - prdata = captured CsrRdData slice; 0 on miss or timeout.
  - pslverr = miss | to | ~hit_q | err_q.
- Error pulses: err_miss / err_timeout pulse for one cycle, coincident with pready.
- Outputs: pready, prdata, pslverr are registered. CsrAddr/CsrWrData/CsrWrEn/CsrWrStrb are driven from capture registers, stable from ISSUE through RESP, 0 in IDLE.
- Minimum latency, normal access: setup T0, CsrCs+ack T1, pready T2.
- Slow read latency: pready at T2 + SLOW_RD_DELAY.
- Ignored inputs: CsrAck on a non-selected channel, or in any state other than ISSUE/WAIT (incl. late ack after timeout).
- psel deasserted while not IDLE (protocol violation): abort to IDLE next cycle; no pready.
- Reset asserted mid-transfer: IDLE next cycle, all outputs 0.

Decomposition:
- Package dfd_apb2mmr_mc_pkg: state enum (IDLE, DELAY, ISSUE, WAIT, RESP); counter-width helper functions.
- Sub-module dfd_apb_addr_decode (combinational): paddr → ch_idx, ch_hit, slow_hit.
- FSM, counters and capture registers live in the top.

Test Plan:
- Write, 64-bit, pstrb=8'hF0 to CH_BASE[1]+8, ack in ISSUE → CsrCs=4'b0010, CsrWrStrb=2'b10, pready at T2, pslverr=0.
- Read CH_BASE[2]+0x10, ack 3 cycles after CsrCs, data 64'hDEAD_BEEF_0123_4567 → pready T5, prdata matches, pslverr=0.
- Read of SLOW_ADDR[0], SLOW_RD_DELAY=2 → CsrCs at T3, pready ≥ T4; write to same address → no delay.
- Address outside all windows → no CsrCs, pready T1, pslverr=1, err_miss=1, prdata=0.
- No ack, TIMEOUT_CYCLES=64 → pready 64 cycles after ISSUE, pslverr=1, err_timeout=1; late ack ignored, next access succeeds.
- Ack with CsrHit=0 or CsrError=1 → pslverr=1; reset mid-WAIT → IDLE, CsrCs/pready=0.
